// File: rtl/wide_lsu_pkg.sv
// Shared definitions for the wide-register load/store engine:
// FSM state encodings, beat/index sizing helpers and a byte-swap helper.
package wide_lsu_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_REQ    = 2'd1;
    localparam state_t ST_WAIT   = 2'd2;
    localparam state_t ST_COMMIT = 2'd3;

    // Widest memory word the byte-swap helper can handle.
    localparam int BSWAP_MAX_W = 512;

    // Number of memory words that make up one wide register.
    function automatic int beats_f(input int wide_w, input int xlen);
        return wide_w / xlen;
    endfunction

    // Width of an index into a table of n entries (at least one bit).
    function automatic int idx_w_f(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Reverse the order of the lowest nbytes bytes of w.
    function automatic logic [BSWAP_MAX_W-1:0] byte_swap(input logic [BSWAP_MAX_W-1:0] w,
                                                         input int nbytes);
        logic [BSWAP_MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < nbytes; i++) begin
            r[8*i +: 8] = w[8*(nbytes-1-i) +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/wide_lsu_if.sv
// Memory request/response port of the wide load/store engine.
// master = the engine, slave = the memory port arbiter.
interface wide_lsu_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) ();
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [XLEN-1:0]   mem_wdata;
    logic              mem_rsp_valid;
    logic [XLEN-1:0]   mem_rdata;

    modport master (
        output mem_req_valid, mem_addr, mem_we, mem_wdata,
        input  mem_req_ready, mem_rsp_valid, mem_rdata
    );

    modport slave (
        input  mem_req_valid, mem_addr, mem_we, mem_wdata,
        output mem_req_ready, mem_rsp_valid, mem_rdata
    );
endinterface

// File: rtl/wide_lsu_regfile.sv
// Wide register file: NUM_WREGS x WIDE_W, reset to zero.
// Two write ports (LSU commit beats the external writer on the same index),
// a combinational external read port and a combinational snapshot port
// used by the engine to capture a register at store acceptance.
module wide_regfile #(
    parameter int WIDE_W    = 256,
    parameter int NUM_WREGS = 8,
    parameter int IDX_W     = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lsu_we,
    input  logic [IDX_W-1:0]  lsu_idx,
    input  logic [WIDE_W-1:0] lsu_data,
    input  logic              ext_we,
    input  logic [IDX_W-1:0]  ext_idx,
    input  logic [WIDE_W-1:0] ext_data,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [WIDE_W-1:0] rd_data,
    input  logic [IDX_W-1:0]  snap_idx,
    output logic [WIDE_W-1:0] snap_data
);

    logic [WIDE_W-1:0] regs_r [NUM_WREGS];

    // Register storage: LSU commit has priority over the external writer.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_WREGS; i++) begin
                regs_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_WREGS; i++) begin
                if (lsu_we && (lsu_idx == IDX_W'(i))) begin
                    regs_r[i] <= lsu_data;
                end else if (ext_we && (ext_idx == IDX_W'(i))) begin
                    regs_r[i] <= ext_data;
                end else begin
                    regs_r[i] <= regs_r[i];
                end
            end
        end
    end

    assign rd_data   = regs_r[rd_idx];
    assign snap_data = regs_r[snap_idx];

endmodule

// File: rtl/wide_lsu.sv
// Multi-beat wide-register load/store engine. Moves a WIDE_W register to or
// from XLEN-wide memory as BEATS sequential word transfers, beat 0 being the
// least-significant word.
// Optional build macro WIDE_LSU_BSWAP_EN adds cmd_bswap: big-endian register
// image (bytes reversed per beat, beat k <-> register word BEATS-1-k).
module wide_lsu
    import wide_lsu_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int WIDE_W    = 256,
    parameter int NUM_WREGS = 8,
    parameter int ADDR_W    = 32
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  cmd_valid,
    output logic                                  cmd_ready,
    input  logic                                  cmd_store,
    input  logic [ADDR_W-1:0]                     cmd_addr,
    input  logic [idx_w_f(NUM_WREGS)-1:0]         cmd_reg,
`ifdef WIDE_LSU_BSWAP_EN
    input  logic                                  cmd_bswap,
`endif
    output logic                                  done,
    output logic                                  err,
    wide_lsu_if.master                            mem,
    input  logic [idx_w_f(NUM_WREGS)-1:0]         rd_idx,
    output logic [WIDE_W-1:0]                     rd_data,
    input  logic                                  wr_en,
    input  logic [idx_w_f(NUM_WREGS)-1:0]         wr_idx,
    input  logic [WIDE_W-1:0]                     wr_data
);

    localparam int BEATS  = beats_f(WIDE_W, XLEN);
    localparam int IDX_W  = idx_w_f(NUM_WREGS);
    localparam int BEAT_W = idx_w_f(BEATS);
    localparam int BYTES  = XLEN / 8;

    state_t              state_r;
    logic [BEAT_W-1:0]   beat_r;
    logic                store_r;
    logic                bswap_r;
    logic [ADDR_W-1:0]   base_r;
    logic [IDX_W-1:0]    reg_r;
    logic [WIDE_W-1:0]   buf_r;
    logic                done_r;
    logic                err_r;
    logic                mem_valid_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic                mem_we_r;
    logic [XLEN-1:0]     mem_wdata_r;

    logic                accept_bswap_s;
    logic                misaligned_s;
    logic [WIDE_W-1:0]   snap_data_s;
    logic [WIDE_W-1:0]   first_src_s;
    logic [BEAT_W-1:0]   nxt_beat_s;
    logic [BEAT_W-1:0]   slot_first_s;
    logic [BEAT_W-1:0]   slot_cur_s;
    logic [BEAT_W-1:0]   slot_nxt_s;
    logic                lsu_we_s;

`ifdef WIDE_LSU_BSWAP_EN
    assign accept_bswap_s = cmd_bswap;
`else
    assign accept_bswap_s = 1'b0;
`endif

    // Register word that a given beat maps to.
    function automatic logic [BEAT_W-1:0] slot_of(input logic [BEAT_W-1:0] b, input logic sw);
        if (sw) begin
            return BEAT_W'(BEATS - 1) - b;
        end else begin
            return b;
        end
    endfunction

    // Byte order of a word crossing between register image and memory.
    function automatic logic [XLEN-1:0] xform(input logic [XLEN-1:0] w, input logic sw);
        if (sw) begin
            return XLEN'(byte_swap(BSWAP_MAX_W'(w), BYTES));
        end else begin
            return w;
        end
    endfunction

    // Beat sequencing helpers and accept-time checks.
    always_comb begin
        nxt_beat_s   = beat_r + 1'b1;
        slot_first_s = slot_of(BEAT_W'(0), accept_bswap_s);
        slot_cur_s   = slot_of(beat_r, bswap_r);
        slot_nxt_s   = slot_of(nxt_beat_s, bswap_r);
        misaligned_s = ((cmd_addr & ADDR_W'(BYTES - 1)) != '0);
        if (cmd_store) begin
            first_src_s = snap_data_s;
        end else begin
            first_src_s = buf_r;
        end
    end

    // Command FSM: accept, issue each beat, wait for its response, commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            beat_r      <= '0;
            store_r     <= 1'b0;
            bswap_r     <= 1'b0;
            base_r      <= '0;
            reg_r       <= '0;
            buf_r       <= '0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            mem_valid_r <= 1'b0;
            mem_addr_r  <= '0;
            mem_we_r    <= 1'b0;
            mem_wdata_r <= '0;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        store_r <= cmd_store;
                        base_r  <= cmd_addr;
                        reg_r   <= cmd_reg;
                        bswap_r <= accept_bswap_s;
                        beat_r  <= '0;
                        if (misaligned_s) begin
                            err_r <= 1'b1;
                        end else begin
                            state_r     <= ST_REQ;
                            mem_valid_r <= 1'b1;
                            mem_addr_r  <= cmd_addr;
                            mem_we_r    <= cmd_store;
                            mem_wdata_r <= xform(first_src_s[slot_first_s*XLEN +: XLEN],
                                                 accept_bswap_s);
                            if (cmd_store) begin
                                buf_r <= snap_data_s;
                            end
                        end
                    end
                end
                ST_REQ: begin
                    if (mem.mem_req_ready) begin
                        mem_valid_r <= 1'b0;
                        state_r     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem.mem_rsp_valid) begin
                        if (!store_r) begin
                            buf_r[slot_cur_s*XLEN +: XLEN] <= xform(mem.mem_rdata, bswap_r);
                        end
                        if (beat_r == BEAT_W'(BEATS - 1)) begin
                            state_r <= ST_COMMIT;
                        end else begin
                            beat_r      <= nxt_beat_s;
                            state_r     <= ST_REQ;
                            mem_valid_r <= 1'b1;
                            mem_addr_r  <= base_r + ADDR_W'(nxt_beat_s) * ADDR_W'(BYTES);
                            mem_wdata_r <= xform(buf_r[slot_nxt_s*XLEN +: XLEN], bswap_r);
                        end
                    end
                end
                ST_COMMIT: begin
                    done_r  <= 1'b1;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    mem_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign lsu_we_s = (state_r == ST_COMMIT) && !store_r;

    wide_regfile #(
        .WIDE_W    (WIDE_W),
        .NUM_WREGS (NUM_WREGS),
        .IDX_W     (IDX_W)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .lsu_we    (lsu_we_s),
        .lsu_idx   (reg_r),
        .lsu_data  (buf_r),
        .ext_we    (wr_en),
        .ext_idx   (wr_idx),
        .ext_data  (wr_data),
        .rd_idx    (rd_idx),
        .rd_data   (rd_data),
        .snap_idx  (cmd_reg),
        .snap_data (snap_data_s)
    );

    assign cmd_ready         = (state_r == ST_IDLE);
    assign done              = done_r;
    assign err               = err_r;
    assign mem.mem_req_valid = mem_valid_r;
    assign mem.mem_addr      = mem_addr_r;
    assign mem.mem_we        = mem_we_r;
    assign mem.mem_wdata     = mem_wdata_r;

endmodule
